// File: rtl/sha_msg_scheduler.sv
// SHA-256 message scheduler: loads one 512-bit block, then streams W0..W(ROUNDS-1)
// over a valid/ready handshake while maintaining the 16-word sliding window.
module sha_msg_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_blk_valid,
  output logic         o_blk_ready,
  input  logic [511:0] i_blk,
  output logic         o_wt_valid,
  input  logic         i_wt_ready,
  output logic [31:0]  o_wt,
  output logic [5:0]   o_t,
  output logic         o_last,
  output logic [511:0] o_words,
  output logic         o_busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t       state;
  state_t       next_state;
  logic [511:0] window;
  logic [5:0]   t;
  logic         load;
  logic         xfer;
  logic         at_last;
  logic [31:0]  new_word;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  assign load    = (state == IDLE) && i_blk_valid;
  assign xfer    = (state == RUN) && i_wt_ready;
  assign at_last = (t == LAST_T);

  // Slot 1 = W[t-2], slot 6 = W[t-7], slot 14 = W[t-15], slot 15 = W[t-16] relative to the new word.
  assign new_word = sigma1(window[63:32]) + window[223:192]
                  + sigma0(window[479:448]) + window[511:480];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (i_blk_valid) next_state = RUN;
      RUN:     if (i_wt_ready && at_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_blk_ready = 1'b0;
    o_wt_valid  = 1'b0;
    o_busy      = 1'b0;
    o_last      = 1'b0;
    case (state)
      IDLE: o_blk_ready = 1'b1;
      RUN: begin
        o_wt_valid = 1'b1;
        o_busy     = 1'b1;
        o_last     = at_last;
      end
      default: o_blk_ready = 1'b0;
    endcase
  end

  // The window keeps its shifted contents after the final transfer; t wraps to 0 so it never exceeds ROUNDS-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      window <= '0;
      t      <= '0;
    end else if (load) begin
      window <= i_blk;
      t      <= '0;
    end else if (xfer) begin
      window <= {window[479:0], new_word};
      t      <= at_last ? 6'd0 : t + 6'd1;
    end
  end

  assign o_wt    = window[511:480];
  assign o_t     = t;
  assign o_words = window;

endmodule

// File: tb/tb_sha_msg_scheduler.sv
// Self-checking bench for sha_msg_scheduler: table vectors, random blocks against a
// word-array reference, stalls, back-to-back blocks, mid-block reset and a ROUNDS=20 build.
module tb_sha_msg_scheduler;

  logic         clk;
  logic         rst;
  logic         blk_valid, blk_ready, wt_valid, wt_ready, last, busy;
  logic [511:0] blk, words;
  logic [31:0]  wt;
  logic [5:0]   t_out;

  logic         blk_valid20, blk_ready20, wt_valid20, wt_ready20, last20, busy20;
  logic [511:0] blk20, words20;
  logic [31:0]  wt20;
  logic [5:0]   t_out20;

  int total;
  int bad;

  logic [31:0] ref_w [80];
  logic [31:0] got_w [64];

  typedef struct packed {
    logic [511:0] blk;
    logic [31:0]  exp_w0;
    logic [31:0]  exp_w16;
    logic [31:0]  exp_w17;
  } vec_t;

  vec_t vecs [3];

  sha_msg_scheduler #(.ROUNDS(64)) dut (
    .i_clk(clk), .i_rst(rst), .i_blk_valid(blk_valid), .o_blk_ready(blk_ready),
    .i_blk(blk), .o_wt_valid(wt_valid), .i_wt_ready(wt_ready), .o_wt(wt),
    .o_t(t_out), .o_last(last), .o_words(words), .o_busy(busy)
  );

  sha_msg_scheduler #(.ROUNDS(20)) dut20 (
    .i_clk(clk), .i_rst(rst), .i_blk_valid(blk_valid20), .o_blk_ready(blk_ready20),
    .i_blk(blk20), .o_wt_valid(wt_valid20), .i_wt_ready(wt_ready20), .o_wt(wt20),
    .o_t(t_out20), .o_last(last20), .o_words(words20), .o_busy(busy20)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Reference schedule: W0..W15 from the block, then the recurrence, far enough to know any later window.
  task automatic buildRef(input logic [511:0] b);
    for (int i = 0; i < 16; i++) ref_w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 80; i++)
      ref_w[i] = sig1(ref_w[i-2]) + ref_w[i-7] + sig0(ref_w[i-15]) + ref_w[i-16];
  endtask

  function automatic logic [511:0] windowAt(input int k);
    logic [511:0] w;
    w = '0;
    for (int s = 0; s < 16; s++) w[32*s +: 32] = ref_w[k + 15 - s];
    return w;
  endfunction

  function automatic logic [511:0] randBlock();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] actual, input logic [511:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [511:0] b);
    checkOutput("blk_ready_before_load", 512'(blk_ready), 512'(1'b1));
    blk       = b;
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic streamWords(input int n_xfer, input int stall_at, input int stall_len);
    for (int k = 0; k < n_xfer; k++) begin
      checkOutput("wt_valid", 512'(wt_valid), 512'(1'b1));
      checkOutput("o_t", 512'(t_out), 512'(k));
      checkOutput("o_wt", 512'(wt), 512'(ref_w[k]));
      checkOutput("o_last", 512'(last), 512'(k == 63));
      got_w[k] = wt;
      if (k == stall_at) begin
        wt_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          checkOutput("stall_wt", 512'(wt), 512'(ref_w[k]));
          checkOutput("stall_t", 512'(t_out), 512'(k));
          checkOutput("stall_words", words, windowAt(k));
          checkOutput("stall_valid", 512'(wt_valid), 512'(1'b1));
        end
      end
      wt_ready = 1'b1;
      @(negedge clk);
    end
    wt_ready = 1'b0;
  endtask

  task automatic checkIdleAfterBlock();
    checkOutput("end_wt_valid", 512'(wt_valid), 512'(1'b0));
    checkOutput("end_blk_ready", 512'(blk_ready), 512'(1'b1));
    checkOutput("end_busy", 512'(busy), 512'(1'b0));
    checkOutput("end_words", words, windowAt(64));
  endtask

  initial begin
    logic [511:0] blk_a;
    logic [511:0] blk_b;
    logic [511:0] abc_blk;
    total = 0;
    bad   = 0;
    rst = 1'b1;
    blk_valid = 1'b0; wt_ready = 1'b0; blk = '0;
    blk_valid20 = 1'b0; wt_ready20 = 1'b0; blk20 = '0;

    repeat (2) @(negedge clk);
    checkOutput("rst_blk_ready", 512'(blk_ready), 512'(1'b1));
    checkOutput("rst_wt_valid", 512'(wt_valid), 512'(1'b0));
    checkOutput("rst_words", words, 512'(0));
    checkOutput("rst_busy", 512'(busy), 512'(1'b0));
    checkOutput("rst_last", 512'(last), 512'(1'b0));
    checkOutput("rst_t", 512'(t_out), 512'(0));
    checkOutput("rst_wt", 512'(wt), 512'(0));
    checkOutput("rst_blk_ready20", 512'(blk_ready20), 512'(1'b1));
    rst = 1'b0;

    wt_ready = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready_valid", 512'(wt_valid), 512'(1'b0));
    checkOutput("idle_ready_t", 512'(t_out), 512'(0));
    wt_ready = 1'b0;

    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0]    = 32'h00000018;
    vecs[0] = '{blk: abc_blk, exp_w0: 32'h61626380, exp_w16: 32'h61626380, exp_w17: 32'h000F0000};
    vecs[1] = '{blk: {512{1'b1}}, exp_w0: 32'hFFFFFFFF, exp_w16: 32'h203FFFFC, exp_w17: 32'h203FFFFC};
    vecs[2] = '{blk: 512'(0), exp_w0: 32'h0, exp_w16: 32'h0, exp_w17: 32'h0};

    for (int i = 0; i < 3; i++) begin
      buildRef(vecs[i].blk);
      applyStimulus(vecs[i].blk);
      streamWords(64, (i == 0) ? 17 : -1, 5);
      checkIdleAfterBlock();
      checkOutput("vec_w0", 512'(got_w[0]), 512'(vecs[i].exp_w0));
      checkOutput("vec_w16", 512'(got_w[16]), 512'(vecs[i].exp_w16));
      checkOutput("vec_w17", 512'(got_w[17]), 512'(vecs[i].exp_w17));
    end

    for (int r = 0; r < 3; r++) begin
      blk_a = randBlock();
      buildRef(blk_a);
      applyStimulus(blk_a);
      streamWords(64, int'($urandom_range(0, 63)), int'($urandom_range(1, 4)));
      checkIdleAfterBlock();
    end

    // Back-to-back: valid held high, second block offered during the first one.
    blk_a = randBlock();
    blk_b = randBlock();
    buildRef(blk_a);
    blk = blk_a;
    blk_valid = 1'b1;
    @(negedge clk);
    blk = blk_b;
    streamWords(64, -1, 0);
    checkIdleAfterBlock();
    buildRef(blk_b);
    @(negedge clk);
    blk_valid = 1'b0;
    checkOutput("b2b_w0", 512'(wt), 512'(blk_b[511:480]));
    streamWords(64, -1, 0);
    checkIdleAfterBlock();

    // Reset in the middle of a block.
    blk_a = randBlock();
    buildRef(blk_a);
    applyStimulus(blk_a);
    streamWords(20, -1, 0);
    checkOutput("pre_rst_t", 512'(t_out), 512'(20));
    rst = 1'b1;
    wt_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_wt_valid", 512'(wt_valid), 512'(1'b0));
    checkOutput("midrst_t", 512'(t_out), 512'(0));
    checkOutput("midrst_blk_ready", 512'(blk_ready), 512'(1'b1));
    checkOutput("midrst_words", words, 512'(0));
    @(negedge clk);
    checkOutput("postrst_wt_valid", 512'(wt_valid), 512'(1'b0));
    wt_ready = 1'b0;

    // ROUNDS=20 instance.
    blk_a = randBlock();
    buildRef(blk_a);
    checkOutput("r20_blk_ready", 512'(blk_ready20), 512'(1'b1));
    blk20 = blk_a;
    blk_valid20 = 1'b1;
    @(negedge clk);
    blk_valid20 = 1'b0;
    wt_ready20 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checkOutput("r20_valid", 512'(wt_valid20), 512'(1'b1));
      checkOutput("r20_t", 512'(t_out20), 512'(k));
      checkOutput("r20_wt", 512'(wt20), 512'(ref_w[k]));
      checkOutput("r20_last", 512'(last20), 512'(k == 19));
      @(negedge clk);
    end
    for (int s = 0; s < 3; s++) begin
      checkOutput("r20_idle_valid", 512'(wt_valid20), 512'(1'b0));
      checkOutput("r20_idle_ready", 512'(blk_ready20), 512'(1'b1));
      checkOutput("r20_idle_busy", 512'(busy20), 512'(1'b0));
      checkOutput("r20_idle_t", 512'(t_out20), 512'(0));
      checkOutput("r20_idle_words", words20, windowAt(20));
      @(negedge clk);
    end
    wt_ready20 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
